vector_load_sequencer: RTL
==========================

# vector_load_sequencer

Sequences one MATRIX_SIZE-element vector from the dual-port RAM into either the left or top input buffer of `systolic_module`, then optionally swaps that buffer's double-buffer halves. Sits between the instruction FSM (issues `start` commands decoded from LOAD_LEFT/LOAD_TOP/SWAP_* instructions) and the DPRAM read port / systolic buffer load ports. Handles the DPRAM 1-cycle read latency, strided addressing, and completion signalling.

## Interface
- DATA_WIDTH, 8, element width
- MATRIX_SIZE, 8, elements per vector (≥2)
- ADDR_WIDTH, $clog2(MATRIX_SIZE), buffer address width
- DP_ADDR_WIDTH, 10, DPRAM address width

Ports. One clock; reset is synchronous and active-high.
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- start  in  1  command strobe, sampled only in IDLE
- target  in  1  0 = left buffer, 1 = top buffer
- base_addr  in  DP_ADDR_WIDTH  DPRAM address of element 0
- stride  in  DP_ADDR_WIDTH  address increment between elements
- swap_after  in  1  pulse swap on target after load
- busy  out  1  high from accept+1 through the done cycle
- done  out  1  one-cycle completion pulse
- ram_addr  out  DP_ADDR_WIDTH  DPRAM port read address (registered)
- ram_dout  in  DATA_WIDTH  DPRAM read data, valid 1 cycle after ram_addr
- load_en_left / load_en_top  out  1  buffer write enables
- buf_addr  out  ADDR_WIDTH  buffer element index
- buf_data  out  DATA_WIDTH  buffer write data (= ram_dout, combinational)
- swap_left / swap_top  out  1  one-cycle swap pulses

## Operation
- States: IDLE, READ, DRAIN, SWAP, DONE.
- IDLE: start=1 latches target, base_addr, stride, swap_after; → READ; ram_addr ← base_addr, rd_cnt ← 0.
- READ: each cycle ram_addr ← ram_addr + stride (modulo 2^DP_ADDR_WIDTH, wrap silently); rd_cnt increments; after MATRIX_SIZE addresses issued → DRAIN.
- Write pipeline: registered valid tracks the issued address; asserted cycle after each issue, driving load_en_<target> with buf_addr = element index 0..MATRIX_SIZE-1. Non-target load_en stays 0.
- DRAIN: final element written; → SWAP if swap_after else DONE.
- SWAP: swap_<target> = 1 for one cycle; → DONE.
- DONE: done = 1 for one cycle; → IDLE.
- start ignored in every state except IDLE; command inputs don't-care outside the accept cycle.
- stride = 0 legal: same address read MATRIX_SIZE times.
- Reset values: busy 0, done 0, ram_addr 0, buf_addr 0, all load_en/swap 0, state IDLE. Reset mid-operation aborts immediately; no further load_en/swap/done; buffer contents undefined (owner re-issues).

## Timing
- Accept at cycle T (start high in IDLE).
- ram_addr = base + i·stride during T+1+i, i = 0..MATRIX_SIZE-1.
- load_en_<target> high with buf_addr = i during T+2+i; last at T+MATRIX_SIZE+1.
- swap_after=1: swap pulse T+MATRIX_SIZE+2, done T+MATRIX_SIZE+3. swap_after=0: done T+MATRIX_SIZE+2.
- busy high T+1 .. done cycle inclusive; earliest next accept is cycle after done.
- Latency start→done: MATRIX_SIZE+2 (no swap) / MATRIX_SIZE+3 (swap); 10/11 at default.
- Back-to-back throughput: one element per cycle within a command.

## Structure
- Shared package `tiny_ctrl_pkg`: state enum `vls_state_t`, target encoding constants TGT_LEFT=0/TGT_TOP=1; shared with the instruction FSM.
- One sub-module: `stride_addr_gen` (loadable base, add-stride, element counter with last flag).

## Test plan
- Left load, base 0x010, stride 1, no swap, RAM[0x010+i]=i+1 → load_en_left T+2..T+9, buf_addr 0..7, data 1..8; done at T+10; load_en_top never high.
- Top load, base 0x3FC, stride 1, swap_after=1 → ram_addr 3FC,3FD,3FE,3FF,000..003; swap_top at T+10; done T+11; swap_left 0.
- Stride 8, base 0x000 (column read) → ram_addr 0,8,…,56; data order matches.
- start held high continuously → accepts at T and T+11 only; no overlap; done pulses exactly once per command.
- rst asserted at T+5 mid-load → next cycle all outputs at reset values, busy 0, no done; new start accepted normally.
- stride 0, base 0x020, RAM[0x020]=0xAA → eight writes of 0xAA, buf_addr 0..7.

Source files
------------

// File: rtl/tiny_ctrl_pkg.sv
// Shared control definitions for the instruction FSM and the vector load sequencer.
package tiny_ctrl_pkg;

    typedef enum logic [2:0] {
        VLS_IDLE  = 3'd0,
        VLS_READ  = 3'd1,
        VLS_DRAIN = 3'd2,
        VLS_SWAP  = 3'd3,
        VLS_DONE  = 3'd4
    } vls_state_t;

    localparam logic TGT_LEFT = 1'b0;
    localparam logic TGT_TOP  = 1'b1;

endpackage

// File: rtl/stride_addr_gen.sv
// Strided DPRAM address generator: loadable base, add-stride advance,
// element counter with a last-element flag.
module stride_addr_gen #(
    parameter int unsigned AW    = 10,
    parameter int unsigned CW    = 3,
    parameter int unsigned COUNT = 8
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          load,
    input  logic          advance,
    input  logic [AW-1:0] base,
    input  logic [AW-1:0] stride,
    output logic [AW-1:0] addr,
    output logic [CW-1:0] cnt,
    output logic          last_c
);

    // Address wraps modulo 2^AW by natural truncation of the sum.
    always_ff @(posedge clk) begin
        if (rst) begin
            addr <= '0;
            cnt  <= '0;
        end else if (load) begin
            addr <= base;
            cnt  <= '0;
        end else if (advance) begin
            addr <= addr + stride;
            cnt  <= cnt + CW'(1);
        end
    end

    assign last_c = (cnt == CW'(COUNT - 1));

endmodule

// File: rtl/vector_load_sequencer.sv
// Streams one MATRIX_SIZE-element vector from the DPRAM into the left or top
// systolic input buffer, then optionally pulses that buffer's swap.
module vector_load_sequencer
    import tiny_ctrl_pkg::*;
#(
    parameter int unsigned DATA_WIDTH    = 8,
    parameter int unsigned MATRIX_SIZE   = 8,
    parameter int unsigned ADDR_WIDTH    = $clog2(MATRIX_SIZE),
    parameter int unsigned DP_ADDR_WIDTH = 10
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     start,
    input  logic                     target,
    input  logic [DP_ADDR_WIDTH-1:0] base_addr,
    input  logic [DP_ADDR_WIDTH-1:0] stride,
    input  logic                     swap_after,
    output logic                     busy,
    output logic                     done,
    output logic [DP_ADDR_WIDTH-1:0] ram_addr,
    input  logic [DATA_WIDTH-1:0]    ram_dout,
    output logic                     load_en_left,
    output logic                     load_en_top,
    output logic [ADDR_WIDTH-1:0]    buf_addr,
    output logic [DATA_WIDTH-1:0]    buf_data,
    output logic                     swap_left,
    output logic                     swap_top
);

    vls_state_t               state_q;
    vls_state_t               state_d;
    logic                     tgt_q;
    logic                     swap_q;
    logic [DP_ADDR_WIDTH-1:0] stride_q;
    logic [ADDR_WIDTH-1:0]    cnt;
    logic                     last_c;
    logic                     accept_c;
    logic                     advance_c;
    logic                     busy_d;
    logic                     done_d;
    logic                     swap_left_d;
    logic                     swap_top_d;
    logic                     load_en_left_d;
    logic                     load_en_top_d;

    assign accept_c  = (state_q == VLS_IDLE) && start;
    assign advance_c = (state_q == VLS_READ) && !last_c;

    stride_addr_gen #(
        .AW    (DP_ADDR_WIDTH),
        .CW    (ADDR_WIDTH),
        .COUNT (MATRIX_SIZE)
    ) u_addr_gen (
        .clk     (clk),
        .rst     (rst),
        .load    (accept_c),
        .advance (advance_c),
        .base    (base_addr),
        .stride  (stride_q),
        .addr    (ram_addr),
        .cnt     (cnt),
        .last_c  (last_c)
    );

    // State register plus the command fields latched at accept.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= VLS_IDLE;
            tgt_q    <= TGT_LEFT;
            swap_q   <= 1'b0;
            stride_q <= '0;
        end else begin
            state_q <= state_d;
            if (accept_c) begin
                tgt_q    <= target;
                swap_q   <= swap_after;
                stride_q <= stride;
            end
        end
    end

    // Outputs are decoded from the next state so the registered copies line up
    // with the state they describe; write enables trail READ by one cycle to
    // absorb the DPRAM read latency.
    always_comb begin
        state_d        = state_q;
        busy_d         = 1'b0;
        done_d         = 1'b0;
        swap_left_d    = 1'b0;
        swap_top_d     = 1'b0;
        load_en_left_d = 1'b0;
        load_en_top_d  = 1'b0;

        unique case (state_q)
            VLS_IDLE:  if (start) state_d = VLS_READ;
            VLS_READ:  if (last_c) state_d = VLS_DRAIN;
            VLS_DRAIN: state_d = swap_q ? VLS_SWAP : VLS_DONE;
            VLS_SWAP:  state_d = VLS_DONE;
            VLS_DONE:  state_d = VLS_IDLE;
            default:   state_d = VLS_IDLE;
        endcase

        busy_d         = (state_d != VLS_IDLE);
        done_d         = (state_d == VLS_DONE);
        swap_left_d    = (state_d == VLS_SWAP) && (tgt_q == TGT_LEFT);
        swap_top_d     = (state_d == VLS_SWAP) && (tgt_q == TGT_TOP);
        load_en_left_d = (state_q == VLS_READ) && (tgt_q == TGT_LEFT);
        load_en_top_d  = (state_q == VLS_READ) && (tgt_q == TGT_TOP);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            busy         <= 1'b0;
            done         <= 1'b0;
            swap_left    <= 1'b0;
            swap_top     <= 1'b0;
            load_en_left <= 1'b0;
            load_en_top  <= 1'b0;
            buf_addr     <= '0;
        end else begin
            busy         <= busy_d;
            done         <= done_d;
            swap_left    <= swap_left_d;
            swap_top     <= swap_top_d;
            load_en_left <= load_en_left_d;
            load_en_top  <= load_en_top_d;
            if (state_q == VLS_READ) buf_addr <= cnt;
        end
    end

    assign buf_data = ram_dout;

endmodule
